mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 4:1 mux (mux4, ports A/SEL/OUT) between 4 requesters.

---
 rtl/mux4_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the SEL input of a shared 4:1 mux, plus the mux itself.
// Define MUX4_ARB_HOLD_LIMIT_EN to force rotation after HOLD_MAX consecutive grant cycles.
module mux4 (
  input  logic [3:0] a_i,
  input  logic [1:0] sel_i,
  output logic       out_o
);
  assign out_o = a_i[sel_i];
endmodule

module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4,
  parameter int RST_SEL  = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic [1:0] pick_s;
  logic       owner_req_s;
  logic       rotate_s;
  logic       grant_s;
  logic       release_s;

  // First requester found scanning upward from ptr+1; ptr itself is examined last.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  assign pick_s      = rr_pick(ptr_q, req_i);
  assign owner_req_s = req_i[ptr_q];

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rotate_s = (cnt_q == CNT_W'(HOLD_MAX - 1)) && (|(req_i & ~gnt_q));

  // Hold counter: cleared on every grant, saturates at HOLD_MAX-1 while owned.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_s) begin
      cnt_d = '0;
    end else if ((state_q == ST_OWN) && (cnt_q != CNT_W'(HOLD_MAX - 1))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg_s;

  assign rotate_s     = 1'b0;
  assign unused_cfg_s = (HOLD_MAX >= 1) && (CNT_W >= 1);
`endif

  // Arbitration decision: new grant, release to idle, or hold.
  always_comb begin
    grant_s   = 1'b0;
    release_s = 1'b0;
    case (state_q)
      ST_IDLE: grant_s = |req_i;
      ST_OWN: begin
        if (owner_req_s && !rotate_s) begin
          grant_s = 1'b0;
        end else if (|req_i) begin
          grant_s = 1'b1;
        end else begin
          release_s = 1'b1;
        end
      end
      default: release_s = 1'b1;
    endcase
  end

  // Next-state values for the state, pointer and registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    if (grant_s) begin
      state_d = ST_OWN;
      ptr_d   = pick_s;
      sel_d   = pick_s;
      gnt_d   = 4'b0001 << pick_s;
      busy_d  = 1'b1;
    end else if (release_s) begin
      state_d = ST_IDLE;
      gnt_d   = 4'b0000;
      busy_d  = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; ptr resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'(RST_SEL);
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter driving a real mux4 from the arbiter SEL.
module tb_mux4_rr_arbiter;
  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 2;
  localparam int RST_SEL  = 1;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] mux_a;
  logic       mux_out;
  int         n_assert;
  int         n_fail;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W), .RST_SEL(RST_SEL)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .sel_o(sel), .busy_o(busy)
  );

  mux4 u_mux (.a_i(mux_a), .sel_i(sel), .out_o(mux_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants checked every cycle on the falling edge.
  always @(negedge clk) begin
    logic [1:0] idx;
    logic       exp_out;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (gnt[i]) idx = 2'(i);
    n_assert++;
    if (!$onehot0(gnt)) begin
      n_fail++; $display("FAIL onehot0: gnt=%b", gnt);
    end
    n_assert++;
    if (busy !== (|gnt)) begin
      n_fail++; $display("FAIL busy_eq_or_gnt: busy=%b gnt=%b", busy, gnt);
    end
    if (busy === 1'b1) begin
      n_assert++;
      if (sel !== idx) begin
        n_fail++; $display("FAIL sel_index: sel=%0d expected %0d", sel, idx);
      end
    end
    exp_out = mux_a[sel];
    n_assert++;
    if (mux_out !== exp_out) begin
      n_fail++; $display("FAIL mux_out: out=%b expected %b", mux_out, exp_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_assert++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'(RST_SEL)) begin
        n_fail++;
        $display("FAIL reset_idle: gnt=%b busy=%b sel=%0d expected 0000/0/%0d", gnt, busy, sel, RST_SEL);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_grant: gnt=%b sel=%0d busy=%b expected 0100/2/1", gnt, sel, busy);
      end
    end
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      n_assert++;
      if (gnt !== 4'b0000 || sel !== 2'd2 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_release: gnt=%b sel=%0d busy=%b expected 0000/2/0", gnt, sel, busy);
      end
    end
  endtask

  task automatic test_rr_release();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    step();
    n_assert++;
    if (gnt !== exp_seq[0]) begin
      n_fail++; $display("FAIL rr_first: gnt=%b expected %b", gnt, exp_seq[0]);
    end
    for (int i = 1; i < 5; i++) begin
      req = 4'b1111 & ~exp_seq[i-1];
      step();
      n_assert++;
      if (gnt !== exp_seq[i] || busy !== 1'b1) begin
        n_fail++; $display("FAIL rr_handover_%0d: gnt=%b busy=%b expected %b/1", i, gnt, busy, exp_seq[i]);
      end
      req = 4'b1111;
      step();
      n_assert++;
      if (gnt !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_hold_%0d: gnt=%b expected %b", i, gnt, exp_seq[i]);
      end
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      step();
      n_assert++;
      if (gnt !== 4'b0010 || sel !== 2'd1) begin
        n_fail++; $display("FAIL no_preempt: gnt=%b sel=%0d expected 0010/1", gnt, sel);
      end
    end
    req = 4'b1000;
    step();
    n_assert++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_fail++; $display("FAIL handover_3: gnt=%b sel=%0d expected 1000/3", gnt, sel);
    end
  endtask

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_g = (((i / HOLD_MAX) % 2) == 1) ? 4'b0010 : 4'b0001;
      n_assert++;
      if (gnt !== exp_g) begin
        n_fail++; $display("FAIL hold_rotate_%0d: gnt=%b expected %b", i, gnt, exp_g);
      end
    end
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      n_assert++;
      if (gnt !== 4'b0001) begin
        n_fail++; $display("FAIL hold_alone_%0d: gnt=%b expected 0001", i, gnt);
      end
    end
  endtask
`else
  task automatic test_hold_limit();
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
      n_assert++;
      if (gnt !== 4'b0001) begin
        n_fail++; $display("FAIL unbounded_hold_%0d: gnt=%b expected 0001", i, gnt);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    step();
    n_assert++;
    if (gnt !== 4'b0100) begin
      n_fail++; $display("FAIL mid_pre: gnt=%b expected 0100", gnt);
    end
    rst = 1'b1;
    #2;
    n_assert++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'(RST_SEL)) begin
      n_fail++; $display("FAIL mid_async_clear: gnt=%b busy=%b sel=%0d expected 0000/0/%0d", gnt, busy, sel, RST_SEL);
    end
    req = 4'b0101;
    step();
    rst = 1'b0;
    step();
    n_assert++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_fail++; $display("FAIL mid_regrant: gnt=%b sel=%0d expected 0001/0", gnt, sel);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mux_a    = 4'b1010;
    rst      = 1'b1;
    req      = 4'b0000;
    test_reset();
    test_single();
    test_rr_release();
    test_no_preempt();
    test_hold_limit();
    test_reset_mid();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
